irq_arbiter: RTL and testbench

Priority interrupt arbiter that collects up to `NSRC` peripheral interrupt lines, gates them by enable, priority and threshold, and drives the core's `external_interrupt` input. It sits on the same Wishbone peripheral bus as the interrupt register block and replaces its software-written external-interrupt bit with a claim/complete handshake. It exposes the winning source ID to the trap handler.

---
 rtl/irq_pkg.sv | 22 ++
 rtl/irq_prio_select.sv | 28 ++
 rtl/irq_arbiter.sv | 158 +++++++++++++++
 tb/tb_irq_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the priority interrupt arbiter: register map,
// source ID width, default priority width and the ID encoding helper.
package irq_pkg;

  localparam int IRQ_ID_W   = 5;
  localparam int IRQ_PRIO_W = 3;

  localparam logic [7:0] IRQ_OFF_PEND   = 8'h00;
  localparam logic [7:0] IRQ_OFF_ENABLE = 8'h04;
  localparam logic [7:0] IRQ_OFF_THRESH = 8'h08;
  localparam logic [7:0] IRQ_OFF_CLAIM  = 8'h0C;
  localparam logic [7:0] IRQ_OFF_EDGE   = 8'h10;
  localparam logic [7:0] IRQ_OFF_PRIO   = 8'h40;

  typedef logic [IRQ_PRIO_W-1:0] prio_t;

  // Source index i is reported as ID i+1; ID 0 is reserved for "none".
  function automatic logic [IRQ_ID_W-1:0] idx_to_id(input int idx);
    return IRQ_ID_W'(idx + 1);
  endfunction

endpackage

// File: rtl/irq_prio_select.sv
// Combinational winner select: highest priority among eligible sources,
// ties resolved toward the lowest source index. Holds no state.
module irq_prio_select
  import irq_pkg::*;
#(
  parameter int NSRC   = 8,
  parameter int PRIO_W = IRQ_PRIO_W
) (
  input  logic [NSRC-1:0]             i_elig,
  input  logic [NSRC-1:0][PRIO_W-1:0] i_prio,
  output logic [IRQ_ID_W-1:0]         o_id,
  output logic [PRIO_W-1:0]           o_prio
);

  // Strict compare while scanning upward keeps the lowest index on a tie;
  // an eligible source always has priority >= 1, so 0 means "no winner".
  always_comb begin
    o_id   = '0;
    o_prio = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (i_elig[i] && (i_prio[i] > o_prio)) begin
        o_id   = idx_to_id(i);
        o_prio = i_prio[i];
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Priority interrupt arbiter with Wishbone claim/complete register block.
// Define IRQ_ARBITER_EDGE_EN to add per-source rising-edge triggering at 0x10.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int NSRC   = 8,
  parameter int PRIO_W = IRQ_PRIO_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     irq_addr,
  input  logic [31:0]     irq_dat_w,
  input  logic [3:0]      irq_sel,
  input  logic            irq_cyc,
  input  logic            irq_stb,
  input  logic [2:0]      irq_cti,
  input  logic [1:0]      irq_bte,
  input  logic            irq_we,
  output logic [31:0]     irq_dat_r,
  output logic            irq_ack,
  output logic            irq_err,
  input  logic [NSRC-1:0] irq_sources,
  output logic            external_interrupt
);

  logic                        r_ack;
  logic [31:0]                 r_dat_r;
  logic [NSRC-1:0]             r_pend;
  logic [NSRC-1:0]             r_insvc;
  logic [NSRC-1:0]             r_en;
  logic [PRIO_W-1:0]           r_thr;
  logic [NSRC-1:0][PRIO_W-1:0] r_prio;
  logic [IRQ_ID_W-1:0]         r_best_id;
  logic                        r_ext;

  logic [7:0]          w_off;
  logic [5:0]          w_pidx;
  logic                w_acc;
  logic                w_rd;
  logic                w_wr;
  logic                w_pwin;
  logic                w_claim;
  logic [IRQ_ID_W-1:0] w_cmp_id;
  logic [IRQ_ID_W-1:0] w_win_id;
  logic [PRIO_W-1:0]   w_win_prio;
  logic [NSRC-1:0]     w_set;
  logic [NSRC-1:0]     w_clm_oh;
  logic [NSRC-1:0]     w_cmp_oh;
  logic [NSRC-1:0]     w_elig;
  logic [31:0]         w_rdata;
  logic                w_unused;

  assign w_unused = ^{irq_cti, irq_bte, irq_addr, irq_dat_w};

  // Reads (and claims) happen on the edge raising ack; writes commit on the
  // following edge while ack is high and the master still holds the strobe.
  assign w_off    = irq_addr[7:0];
  assign w_acc    = !r_ack && irq_cyc && irq_stb;
  assign w_rd     = w_acc && !irq_we;
  assign w_wr     = r_ack && irq_cyc && irq_stb && irq_we && (irq_sel == 4'hF);
  assign w_pidx   = irq_addr[7:2] - 6'h10;
  assign w_pwin   = (w_off >= IRQ_OFF_PRIO) && (w_off[1:0] == 2'b00);
  assign w_cmp_id = irq_dat_w[IRQ_ID_W-1:0];
  assign w_claim  = w_rd && (w_off == IRQ_OFF_CLAIM) && (r_best_id != '0);

  // In-service sources are masked so an edge latched during service waits
  // for the complete before it is presented again.
  always_comb begin
    w_clm_oh = '0;
    w_cmp_oh = '0;
    w_elig   = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_clm_oh[i] = w_claim && (r_best_id == idx_to_id(i));
      w_cmp_oh[i] = w_wr && (w_off == IRQ_OFF_CLAIM) && (w_cmp_id == idx_to_id(i));
      w_elig[i]   = r_pend[i] && !r_insvc[i] && r_en[i] && (r_prio[i] > r_thr);
    end
  end

`ifdef IRQ_ARBITER_EDGE_EN
  logic [NSRC-1:0] r_edge;
  logic [NSRC-1:0] r_src_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_edge  <= '0;
      r_src_q <= '0;
    end else begin
      r_src_q <= irq_sources;
      if (w_wr && (w_off == IRQ_OFF_EDGE)) r_edge <= irq_dat_w[NSRC-1:0];
    end
  end

  assign w_set = (r_edge & irq_sources & ~r_src_q)
               | (~r_edge & irq_sources & ~r_insvc & ~w_clm_oh);
`else
  assign w_set = irq_sources & ~r_insvc & ~w_clm_oh;
`endif

  irq_prio_select #(
    .NSRC   (NSRC),
    .PRIO_W (PRIO_W)
  ) u_sel (
    .i_elig (w_elig),
    .i_prio (r_prio),
    .o_id   (w_win_id),
    .o_prio (w_win_prio)
  );

  always_comb begin
    w_rdata = '0;
    case (w_off)
      IRQ_OFF_PEND:   w_rdata[NSRC-1:0]     = r_pend;
      IRQ_OFF_ENABLE: w_rdata[NSRC-1:0]     = r_en;
      IRQ_OFF_THRESH: w_rdata[PRIO_W-1:0]   = r_thr;
      IRQ_OFF_CLAIM:  w_rdata[IRQ_ID_W-1:0] = r_best_id;
`ifdef IRQ_ARBITER_EDGE_EN
      IRQ_OFF_EDGE:   w_rdata[NSRC-1:0]     = r_edge;
`endif
      default: ;
    endcase
    for (int i = 0; i < NSRC; i++) begin
      if (w_pwin && (w_pidx == 6'(i))) w_rdata[PRIO_W-1:0] = r_prio[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack     <= 1'b0;
      r_dat_r   <= '0;
      r_pend    <= '0;
      r_insvc   <= '0;
      r_en      <= '0;
      r_thr     <= '0;
      r_prio    <= '0;
      r_best_id <= '0;
      r_ext     <= 1'b0;
    end else begin
      r_ack <= w_acc;
      if (w_rd) r_dat_r <= w_rdata;
      // A claimed level source is blocked from re-pending on its claim edge.
      r_pend    <= (r_pend & ~w_clm_oh) | w_set;
      r_insvc   <= (r_insvc & ~w_cmp_oh) | w_clm_oh;
      r_best_id <= w_win_id;
      r_ext     <= (w_win_prio != '0);
      if (w_wr && (w_off == IRQ_OFF_ENABLE)) r_en  <= irq_dat_w[NSRC-1:0];
      if (w_wr && (w_off == IRQ_OFF_THRESH)) r_thr <= irq_dat_w[PRIO_W-1:0];
      for (int i = 0; i < NSRC; i++) begin
        if (w_wr && w_pwin && (w_pidx == 6'(i))) r_prio[i] <= irq_dat_w[PRIO_W-1:0];
      end
    end
  end

  assign irq_ack            = r_ack;
  assign irq_dat_r          = r_dat_r;
  assign irq_err            = 1'b0;
  assign external_interrupt = r_ext;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: vector table of bus ops with expected read
// data and interrupt level, plus hand sequences for the cycle-exact cases.
module tb_irq_arbiter;
  import irq_pkg::*;

  localparam int NSRC = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     irq_addr = '0;
  logic [31:0]     irq_dat_w = '0;
  logic [3:0]      irq_sel = 4'hF;
  logic            irq_cyc = 1'b0;
  logic            irq_stb = 1'b0;
  logic [2:0]      irq_cti = 3'b000;
  logic [1:0]      irq_bte = 2'b00;
  logic            irq_we = 1'b0;
  logic [31:0]     irq_dat_r;
  logic            irq_ack;
  logic            irq_err;
  logic [NSRC-1:0] irq_sources = '0;
  logic            external_interrupt;

  always #5 clk = ~clk;

  irq_arbiter #(.NSRC(NSRC), .PRIO_W(IRQ_PRIO_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .irq_addr           (irq_addr),
    .irq_dat_w          (irq_dat_w),
    .irq_sel            (irq_sel),
    .irq_cyc            (irq_cyc),
    .irq_stb            (irq_stb),
    .irq_cti            (irq_cti),
    .irq_bte            (irq_bte),
    .irq_we             (irq_we),
    .irq_dat_r          (irq_dat_r),
    .irq_ack            (irq_ack),
    .irq_err            (irq_err),
    .irq_sources        (irq_sources),
    .external_interrupt (external_interrupt)
  );

  typedef struct {
    logic [NSRC-1:0] src;
    bit              we;
    logic [7:0]      addr;
    logic [31:0]     dat;
    logic [3:0]      sel;
    logic [31:0]     exp;
    bit              ext;
  } vec_t;

  vec_t        vecs[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] rd;
  logic        ea;

  function automatic void add_r(input logic [NSRC-1:0] s, input logic [7:0] a,
                                input logic [31:0] e, input bit x);
    vec_t v;
    v.src = s; v.we = 1'b0; v.addr = a; v.dat = '0; v.sel = 4'hF; v.exp = e; v.ext = x;
    vecs.push_back(v);
  endfunction

  function automatic void add_w(input logic [NSRC-1:0] s, input logic [7:0] a,
                                input logic [31:0] d, input logic [3:0] sl, input bit x);
    vec_t v;
    v.src = s; v.we = 1'b1; v.addr = a; v.dat = d; v.sel = sl; v.exp = '0; v.ext = x;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called at posedge+1; returns at posedge+1 of the edge after the ack edge.
  task automatic wb(input bit we, input logic [7:0] a, input logic [31:0] d,
                    input logic [3:0] sl, output logic [31:0] rdat, output logic ext_ack);
    int n;
    irq_addr = {24'h0, a}; irq_dat_w = d; irq_sel = sl; irq_we = we;
    irq_cyc = 1'b1; irq_stb = 1'b1;
    rdat = '0; ext_ack = 1'b0;
    for (n = 0; n < 8 && !irq_ack; n++) tick(1);
    if (!irq_ack) begin
      n_tests++; n_fail++;
      $display("FAIL ack_timeout: addr 0x%0h got no ack expected ack within 8 cycles", a);
    end else begin
      rdat = irq_dat_r; ext_ack = external_interrupt;
      tick(1);
    end
    irq_cyc = 1'b0; irq_stb = 1'b0; irq_we = 1'b0;
  endtask

  task automatic do_reset;
    irq_cyc = 1'b0; irq_stb = 1'b0; irq_we = 1'b0; irq_sources = '0;
    rst = 1'b1; tick(2); rst = 1'b0; tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation got no finish expected finish before 100000");
    $fatal(1);
  end

  initial begin
    // ---- reset asserted in the middle of a claim read
    do_reset();
    wb(1, 8'h40, 32'd5, 4'hF, rd, ea);
    wb(1, 8'h04, 32'h01, 4'hF, rd, ea);
    irq_sources = 8'h01;
    tick(2);
    chk("pre_reset_ext", {31'b0, external_interrupt}, 32'd1);
    irq_addr = 32'h0C; irq_we = 1'b0; irq_cyc = 1'b1; irq_stb = 1'b1;
    #2 rst = 1'b1;
    tick(1);
    chk("rst_ack0_a", {31'b0, irq_ack}, 32'd0);
    chk("rst_ext0", {31'b0, external_interrupt}, 32'd0);
    tick(1);
    chk("rst_ack0_b", {31'b0, irq_ack}, 32'd0);
    chk("rst_dat_r0", irq_dat_r, 32'd0);
    chk("err_tied0", {31'b0, irq_err}, 32'd0);
    irq_cyc = 1'b0; irq_stb = 1'b0; irq_sources = '0;
    rst = 1'b0;
    tick(1);

    // ---- vector table
    add_r(8'h00, 8'h00, 32'h0, 0);          // readback after reset
    add_r(8'h00, 8'h04, 32'h0, 0);
    add_r(8'h00, 8'h08, 32'h0, 0);
    add_r(8'h00, 8'h0C, 32'h0, 0);
    add_r(8'h00, 8'h40, 32'h0, 0);
    add_r(8'h00, 8'h10, 32'h0, 0);
    add_w(8'h00, 8'h48, 32'd3, 4'hF, 0);    // basic claim/complete
    add_w(8'h00, 8'h04, 32'h04, 4'hF, 0);
    add_w(8'h00, 8'h08, 32'd0, 4'hF, 0);
    add_r(8'h04, 8'h00, 32'h04, 1);
    add_r(8'h04, 8'h0C, 32'd3, 0);
    add_r(8'h04, 8'h00, 32'h00, 0);
    add_w(8'h04, 8'h0C, 32'd3, 4'hF, 1);
    add_r(8'h04, 8'h00, 32'h04, 1);
    add_r(8'h00, 8'h0C, 32'd3, 0);
    add_w(8'h00, 8'h0C, 32'd3, 4'hF, 0);
    add_w(8'h00, 8'h44, 32'd4, 4'hF, 0);    // arbitration
    add_w(8'h00, 8'h54, 32'd4, 4'hF, 0);
    add_w(8'h00, 8'h4C, 32'd2, 4'hF, 0);
    add_w(8'h2A, 8'h04, 32'hFF, 4'hF, 1);
    add_r(8'h2A, 8'h00, 32'h2A, 1);
    add_r(8'h00, 8'h0C, 32'd2, 1);
    add_r(8'h00, 8'h0C, 32'd6, 1);
    add_r(8'h00, 8'h0C, 32'd4, 0);
    add_r(8'h00, 8'h0C, 32'd0, 0);
    add_r(8'h00, 8'h00, 32'h00, 0);
    add_w(8'h00, 8'h0C, 32'd0, 4'hF, 0);    // bad completes
    add_w(8'h00, 8'h0C, 32'd9, 4'hF, 0);
    add_w(8'h00, 8'h0C, 32'd1, 4'hF, 0);
    add_w(8'h00, 8'h0C, 32'd2, 4'h3, 0);
    add_r(8'h2A, 8'h00, 32'h00, 0);
    add_w(8'h2A, 8'h0C, 32'd2, 4'hF, 1);
    add_r(8'h2A, 8'h00, 32'h02, 1);
    add_r(8'h00, 8'h0C, 32'd2, 0);
    add_w(8'h00, 8'h40, 32'd4, 4'hF, 0);    // threshold / enable
    add_w(8'h00, 8'h08, 32'd4, 4'hF, 0);
    add_r(8'h01, 8'h00, 32'h01, 0);
    add_w(8'h01, 8'h08, 32'd3, 4'hF, 1);
    add_w(8'h01, 8'h04, 32'hFE, 4'hF, 0);
    add_r(8'h01, 8'h00, 32'h01, 0);
    add_r(8'h01, 8'h08, 32'd3, 0);
    add_r(8'h01, 8'h04, 32'hFE, 0);
    add_r(8'h01, 8'h40, 32'd4, 0);
    add_r(8'h01, 8'h4C, 32'd2, 0);
    add_w(8'h01, 8'h00, 32'hFF, 4'hF, 0);   // read-only / unmapped
    add_r(8'h01, 8'h00, 32'h01, 0);
    add_w(8'h01, 8'h60, 32'd7, 4'hF, 0);
    add_r(8'h01, 8'h60, 32'h0, 0);
    add_r(8'h01, 8'h20, 32'h0, 0);
    add_w(8'h01, 8'h04, 32'hFFFFFFFF, 4'h7, 0);
    add_r(8'h01, 8'h04, 32'hFE, 0);

    foreach (vecs[i]) begin
      irq_sources = vecs[i].src;
      tick(2);
      wb(vecs[i].we, vecs[i].addr, vecs[i].dat, vecs[i].sel, rd, ea);
      if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      tick(2);
      chk($sformatf("vec%0d_ext", i), {31'b0, external_interrupt}, {31'b0, vecs[i].ext});
    end

    // ---- exact latencies: source->interrupt, claim drop, complete re-pend
    do_reset();
    wb(1, 8'h48, 32'd3, 4'hF, rd, ea);
    wb(1, 8'h04, 32'h04, 4'hF, rd, ea);
    irq_sources = 8'h04;
    tick(1);
    chk("lat_edge1_ext", {31'b0, external_interrupt}, 32'd0);
    tick(1);
    chk("lat_edge2_ext", {31'b0, external_interrupt}, 32'd1);
    wb(0, 8'h0C, 32'd0, 4'hF, rd, ea);
    chk("claim_id", rd, 32'd3);
    chk("claim_ext_at_ack", {31'b0, ea}, 32'd1);
    chk("claim_ext_drop", {31'b0, external_interrupt}, 32'd0);
    wb(1, 8'h0C, 32'd3, 4'hF, rd, ea);
    chk("cmpl_ext_e0", {31'b0, external_interrupt}, 32'd0);
    tick(1);
    chk("cmpl_ext_e1", {31'b0, external_interrupt}, 32'd0);
    tick(1);
    chk("cmpl_ext_e2", {31'b0, external_interrupt}, 32'd1);

    // ---- threshold and enable writes take effect one edge after the ack
    do_reset();
    wb(1, 8'h40, 32'd4, 4'hF, rd, ea);
    wb(1, 8'h04, 32'h01, 4'hF, rd, ea);
    wb(1, 8'h08, 32'd4, 4'hF, rd, ea);
    irq_sources = 8'h01;
    tick(3);
    chk("thr4_ext", {31'b0, external_interrupt}, 32'd0);
    wb(1, 8'h08, 32'd3, 4'hF, rd, ea);
    chk("thr3_ext_e0", {31'b0, external_interrupt}, 32'd0);
    tick(1);
    chk("thr3_ext_e1", {31'b0, external_interrupt}, 32'd1);
    wb(1, 8'h04, 32'h00, 4'hF, rd, ea);
    chk("dis_ext_e0", {31'b0, external_interrupt}, 32'd1);
    tick(1);
    chk("dis_ext_e1", {31'b0, external_interrupt}, 32'd0);
    wb(0, 8'h00, 32'd0, 4'hF, rd, ea);
    chk("dis_pend_kept", rd, 32'h01);

`ifdef IRQ_ARBITER_EDGE_EN
    // ---- edge-triggered source 4
    do_reset();
    wb(1, 8'h50, 32'd2, 4'hF, rd, ea);
    wb(1, 8'h04, 32'h10, 4'hF, rd, ea);
    wb(1, 8'h10, 32'h10, 4'hF, rd, ea);
    wb(0, 8'h10, 32'd0, 4'hF, rd, ea);
    chk("edge_reg_rd", rd, 32'h10);
    irq_sources = 8'h10; tick(1); irq_sources = 8'h00;
    tick(1);
    chk("edge_pulse_ext", {31'b0, external_interrupt}, 32'd1);
    wb(0, 8'h00, 32'd0, 4'hF, rd, ea);
    chk("edge_pend", rd, 32'h10);
    wb(0, 8'h0C, 32'd0, 4'hF, rd, ea);
    chk("edge_claim1", rd, 32'd5);
    irq_sources = 8'h10; tick(1); irq_sources = 8'h00;
    tick(3);
    chk("edge_insvc_ext", {31'b0, external_interrupt}, 32'd0);
    wb(0, 8'h00, 32'd0, 4'hF, rd, ea);
    chk("edge_pend_latched", rd, 32'h10);
    wb(1, 8'h0C, 32'd5, 4'hF, rd, ea);
    tick(1);
    chk("edge_after_cmpl_ext", {31'b0, external_interrupt}, 32'd1);
    wb(0, 8'h0C, 32'd0, 4'hF, rd, ea);
    chk("edge_claim2", rd, 32'd5);
`else
    // ---- without edge support 0x10 is unmapped
    wb(1, 8'h10, 32'hFF, 4'hF, rd, ea);
    wb(0, 8'h10, 32'd0, 4'hF, rd, ea);
    chk("edge_reg_absent", rd, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
